// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port and
// defers redirects that arrive while fetch is stalled.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        pc_valid,
  output logic [63:0] pc,
  output logic        inst_sram_en,
  output logic [7:0]  inst_sram_we,
  output logic [63:0] inst_sram_addr,
  output logic [63:0] inst_sram_wdata,
  output logic        fetch_misalign,
  output logic [63:0] fetch_cnt
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [63:0] pend_addr_q, pend_addr_d;
  logic [63:0] fetch_cnt_q, fetch_cnt_d;

  logic fetch_stall;
  logic running;
  logic unused_stall;

  assign fetch_stall  = stall[0];
  assign unused_stall = ^stall[5:1];
  assign running      = (state_q == RUN);

  assign pc              = pc_q;
  assign fetch_misalign  = running && (pc_q[1:0] != 2'b00);
  assign inst_sram_en    = running && !fetch_misalign;
  // A held pc behind a pending redirect is wrong-path, so it is not handed to decode.
  assign pc_valid        = running && !fetch_misalign && !pend_v_q;
  assign inst_sram_we    = 8'h00;
  assign inst_sram_addr  = {pc_q[63:3], 3'b000};
  assign inst_sram_wdata = 64'h0;
  assign fetch_cnt       = fetch_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    fetch_cnt_d = fetch_cnt_q;

    if (state_q == BOOT) begin
      state_d = RUN;
    end else begin
      if (br_e && !fetch_stall) begin
        pc_d     = br_addr;
        pend_v_d = 1'b0;
      end else if (br_e) begin
        pend_v_d    = 1'b1;
        pend_addr_d = br_addr;
      end else if (pend_v_q && !fetch_stall) begin
        pc_d     = pend_addr_q;
        pend_v_d = 1'b0;
      end else if (fetch_misalign) begin
        pc_d = pc_q;
      end else if (!fetch_stall) begin
        pc_d = pc_q + 64'd4;
      end

      if (pc_valid && !fetch_stall && !br_e) begin
        fetch_cnt_d = fetch_cnt_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 64'h0;
      fetch_cnt_q <= 64'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, sequential fetch, stalls, redirects,
// misaligned targets and asynchronous mid-run reset.
module tb_if_stage;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        br_e;
  logic [63:0] br_addr;
  logic        pc_valid;
  logic [63:0] pc;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_we;
  logic [63:0] inst_sram_addr;
  logic [63:0] inst_sram_wdata;
  logic        fetch_misalign;
  logic [63:0] fetch_cnt;

  int vectors = 0;
  int miscompares = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_e(br_e), .br_addr(br_addr),
    .pc_valid(pc_valid), .pc(pc), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .fetch_misalign(fetch_misalign),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 6'h0; br_e = 1'b0; br_addr = 64'h0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'h0; br_e = 1'b0; br_addr = 64'h0;
    step(); step();
    vectors++; if (pc !== RPC) begin miscompares++; $display("[TB] FAIL reset_pc got %h want %h", pc, RPC); end
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pc_valid got %b want 0", pc_valid); end
    vectors++; if (inst_sram_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en got %b want 0", inst_sram_en); end
    vectors++; if (inst_sram_we !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_we got %h want 00", inst_sram_we); end
    vectors++; if (inst_sram_addr !== 64'h8000_0000) begin miscompares++; $display("[TB] FAIL reset_addr got %h want 80000000", inst_sram_addr); end
    vectors++; if (inst_sram_wdata !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_wdata got %h want 0", inst_sram_wdata); end
    vectors++; if (fetch_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_misalign got %b want 0", fetch_misalign); end
    vectors++; if (fetch_cnt !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_cnt got %0d want 0", fetch_cnt); end
    rst = 1'b0;
    #2;
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL boot_pc_valid got %b want 0", pc_valid); end
    vectors++; if (inst_sram_en !== 1'b0) begin miscompares++; $display("[TB] FAIL boot_en got %b want 0", inst_sram_en); end
    step();
    vectors++; if (pc_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL run_pc_valid got %b want 1", pc_valid); end
    vectors++; if (inst_sram_en !== 1'b1) begin miscompares++; $display("[TB] FAIL run_en got %b want 1", inst_sram_en); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [4];
    logic [63:0] exp_addr [4];
    exp_pc   = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
    exp_addr = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0008, 64'h8000_0008};
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pc !== exp_pc[i]) begin miscompares++; $display("[TB] FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
      vectors++; if (inst_sram_addr !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL seq_addr[%0d] got %h want %h", i, inst_sram_addr, exp_addr[i]); end
      vectors++; if (fetch_cnt !== 64'(i)) begin miscompares++; $display("[TB] FAIL seq_cnt[%0d] got %0d want %0d", i, fetch_cnt, i); end
      if (i < 3) step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    vectors++; if (pc !== 64'h8000_0008) begin miscompares++; $display("[TB] FAIL stall_setup_pc got %h want 80000008", pc); end
    stall = 6'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (pc !== 64'h8000_0008) begin miscompares++; $display("[TB] FAIL stall_pc[%0d] got %h want 80000008", i, pc); end
      vectors++; if (inst_sram_en !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_en[%0d] got %b want 1", i, inst_sram_en); end
      vectors++; if (fetch_cnt !== 64'd2) begin miscompares++; $display("[TB] FAIL stall_cnt[%0d] got %0d want 2", i, fetch_cnt); end
    end
    stall = 6'h02;
    step();
    vectors++; if (pc !== 64'h8000_000C) begin miscompares++; $display("[TB] FAIL stall_release_pc got %h want 8000000c", pc); end
    vectors++; if (fetch_cnt !== 64'd3) begin miscompares++; $display("[TB] FAIL stall_release_cnt got %0d want 3", fetch_cnt); end
    stall = 6'h00;
    step();
    vectors++; if (pc !== 64'h8000_0010) begin miscompares++; $display("[TB] FAIL stall_next_pc got %h want 80000010", pc); end
  endtask

  task automatic test_branch();
    br_e = 1'b1; br_addr = 64'h8000_0100;
    step();
    br_e = 1'b0;
    vectors++; if (pc !== 64'h8000_0100) begin miscompares++; $display("[TB] FAIL br_pc got %h want 80000100", pc); end
    vectors++; if (pc_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL br_pc_valid got %b want 1", pc_valid); end
    vectors++; if (fetch_cnt !== 64'd4) begin miscompares++; $display("[TB] FAIL br_cnt got %0d want 4", fetch_cnt); end
    step();
    vectors++; if (pc !== 64'h8000_0104) begin miscompares++; $display("[TB] FAIL br_next_pc got %h want 80000104", pc); end
    vectors++; if (fetch_cnt !== 64'd5) begin miscompares++; $display("[TB] FAIL br_next_cnt got %0d want 5", fetch_cnt); end
  endtask

  task automatic test_redirect_stall();
    stall = 6'h01; br_e = 1'b1; br_addr = 64'h8000_0200;
    step();
    vectors++; if (pc !== 64'h8000_0104) begin miscompares++; $display("[TB] FAIL pend1_pc got %h want 80000104", pc); end
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pend1_pc_valid got %b want 0", pc_valid); end
    br_addr = 64'h8000_0300;
    step();
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pend2_pc_valid got %b want 0", pc_valid); end
    br_e = 1'b0;
    step();
    vectors++; if (pc !== 64'h8000_0104) begin miscompares++; $display("[TB] FAIL pend3_pc got %h want 80000104", pc); end
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pend3_pc_valid got %b want 0", pc_valid); end
    stall = 6'h00;
    step();
    vectors++; if (pc !== 64'h8000_0300) begin miscompares++; $display("[TB] FAIL pend_release_pc got %h want 80000300", pc); end
    vectors++; if (pc_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pend_release_valid got %b want 1", pc_valid); end
    vectors++; if (fetch_cnt !== 64'd5) begin miscompares++; $display("[TB] FAIL pend_release_cnt got %0d want 5", fetch_cnt); end
    step();
    vectors++; if (pc !== 64'h8000_0304) begin miscompares++; $display("[TB] FAIL pend_next_pc got %h want 80000304", pc); end
    vectors++; if (fetch_cnt !== 64'd6) begin miscompares++; $display("[TB] FAIL pend_next_cnt got %0d want 6", fetch_cnt); end
  endtask

  task automatic test_misalign();
    br_e = 1'b1; br_addr = 64'h8000_0402;
    step();
    br_e = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (fetch_misalign !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_flag[%0d] got %b want 1", i, fetch_misalign); end
      vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_pc_valid[%0d] got %b want 0", i, pc_valid); end
      vectors++; if (inst_sram_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_en[%0d] got %b want 0", i, inst_sram_en); end
      vectors++; if (pc !== 64'h8000_0402) begin miscompares++; $display("[TB] FAIL mis_pc[%0d] got %h want 80000402", i, pc); end
      vectors++; if (inst_sram_addr !== 64'h8000_0400) begin miscompares++; $display("[TB] FAIL mis_addr[%0d] got %h want 80000400", i, inst_sram_addr); end
      step();
    end
    vectors++; if (fetch_cnt !== 64'd6) begin miscompares++; $display("[TB] FAIL mis_cnt got %0d want 6", fetch_cnt); end
    br_e = 1'b1; br_addr = 64'h8000_0500;
    step();
    br_e = 1'b0;
    vectors++; if (fetch_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_clear_flag got %b want 0", fetch_misalign); end
    vectors++; if (pc !== 64'h8000_0500) begin miscompares++; $display("[TB] FAIL mis_clear_pc got %h want 80000500", pc); end
    vectors++; if (pc_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_clear_valid got %b want 1", pc_valid); end
    step();
    vectors++; if (fetch_cnt !== 64'd7) begin miscompares++; $display("[TB] FAIL mis_next_cnt got %0d want 7", fetch_cnt); end
  endtask

  task automatic test_mid_reset();
    stall = 6'h01; br_e = 1'b1; br_addr = 64'h8000_0600;
    step();
    br_e = 1'b0;
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_pending_valid got %b want 0", pc_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (pc !== RPC) begin miscompares++; $display("[TB] FAIL mr_pc got %h want %h", pc, RPC); end
    vectors++; if (fetch_cnt !== 64'h0) begin miscompares++; $display("[TB] FAIL mr_cnt got %0d want 0", fetch_cnt); end
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_pc_valid got %b want 0", pc_valid); end
    vectors++; if (inst_sram_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_en got %b want 0", inst_sram_en); end
    stall = 6'h00;
    step();
    rst = 1'b0;
    step();
    vectors++; if (pc !== RPC) begin miscompares++; $display("[TB] FAIL mr_restart_pc got %h want %h", pc, RPC); end
    vectors++; if (pc_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_restart_valid got %b want 1", pc_valid); end
    step();
    vectors++; if (pc !== 64'h8000_0004) begin miscompares++; $display("[TB] FAIL mr_no_pending_pc got %h want 80000004", pc); end
    vectors++; if (fetch_cnt !== 64'd1) begin miscompares++; $display("[TB] FAIL mr_restart_cnt got %0d want 1", fetch_cnt); end
  endtask

  initial begin
    rst = 1'b1; stall = 6'h0; br_e = 1'b0; br_addr = 64'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_redirect_stall();
    test_misalign();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and drives the instruction SRAM read port with a 64-bit-aligned address. It hands `pc`/`pc_valid` to decode, which takes the SRAM read data one cycle later. It handles the pipeline stall vector, branch redirects (including redirects that arrive while fetch is stalled), misaligned fetch targets and a retired-fetch counter.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  6: pipeline stall vector; bit 0 = fetch stalled, bit 1 = decode stalled.
- `br_e`  in  1: branch/redirect request from execute, valid this cycle.
- `br_addr`  in  64: redirect target, qualified by `br_e`.
- `pc_valid`  out  1: `pc` is a real fetch (not a bubble).
- `pc`  out  64: address of the instruction being fetched this cycle.
- `inst_sram_en`  out  1: SRAM read enable.
- `inst_sram_we`  out  8: byte write enables, constant 0.
- `inst_sram_addr`  out  64: `{pc[63:3],3'b000}`.
- `inst_sram_wdata`  out  64: constant 0.
- `fetch_misalign`  out  1: current `pc[1:0]` != 0 while running.
- `fetch_cnt`  out  64: count of fetches accepted by decode.

## Operation
- Two-state FSM: BOOT (reset state) and RUN.
  - BOOT -> RUN on the first clock edge after `rst` deasserts; `pc` is unchanged by this edge.
  - RUN is left only by `rst`.
- Internal state: `pc_reg`, `pend_v` (1 bit), `pend_addr` (64 bits), `fetch_cnt`.
- In BOOT: `pc_valid`=0 and `inst_sram_en`=0.
- In RUN:
  - `inst_sram_en` = !`fetch_misalign`.
  - `pc_valid` = !`fetch_misalign`.
- `pc` = `pc_reg`. SRAM is synchronous-read: data for `pc` appears the following cycle, aligned with decode's latched pc.
- Next-PC selection in RUN, highest priority first:
  1. `br_e` & !`stall[0]`: `pc_reg`<=`br_addr`; `pend_v`<=0.
  2. `br_e` & `stall[0]`: `pend_v`<=1; `pend_addr`<=`br_addr` (a newer redirect overwrites an older pending one); `pc_reg` holds.
  3. `pend_v` & !`stall[0]`: `pc_reg`<=`pend_addr`; `pend_v`<=0.
  4. `fetch_misalign`: `pc_reg` holds (stuck until a redirect).
  5. !`stall[0]`: `pc_reg`<=`pc_reg`+4, with 64-bit wrap.
  6. Otherwise `pc_reg` holds.
- While `pend_v`=1, `pc_valid` is forced 0: the held pc is wrong-path.
- `fetch_cnt` increments at an edge where all of the following hold: `pc_valid`=1, `stall[0]`=0, `br_e`=0. It wraps at 2^64.
- The redirect target is fetched unconditionally. If the target is misaligned, `fetch_misalign` rises on the next cycle with `pc_valid`=0.
- Asserting `rst` in any state clears everything immediately, including a pending redirect.

## Timing
- Reset values: `pc`=`RESET_PC`, `pc_valid`=0, `inst_sram_en`=0, `inst_sram_we`=0, `inst_sram_addr`=`{RESET_PC[63:3],3'b0}`, `inst_sram_wdata`=0, `fetch_misalign`=0, `fetch_cnt`=0; `pend_v`=0.
- Cycle 0 after reset release: BOOT, outputs as at reset. Cycle 1: RUN, `pc`=`RESET_PC`, `pc_valid`=1, `inst_sram_en`=1.
- Sequential fetch: one new pc per unstalled cycle.
- Redirect latency:
  - `br_e` in cycle n, unstalled: `pc`=`br_addr` in cycle n+1.
  - Redirect deferred through the pending register: `pc`=`pend_addr` in the cycle after the first cycle with `stall[0]`=0.
- `br_e` and `stall[0]` in the same cycle never lose the redirect.
- Outputs are combinational from registered state only. There is no combinational path from `br_e` or `stall` to outputs, except that `inst_sram_addr` follows `pc`.

## Test plan
- Reset then run: `RESET_PC`=0x8000_0000, no stall for 4 cycles.
  - Required: `pc` = 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C.
  - Required: `inst_sram_addr` = 0x8000_0000, 0x8000_0000, 0x8000_0008, 0x8000_0008.
  - Required: `fetch_cnt`=3 after the fourth edge.
- Stall: assert `stall[0]` for 3 cycles at `pc`=0x8000_0008.
  - Required: `pc` holds 0x8000_0008, `inst_sram_en` stays 1, `fetch_cnt` frozen.
  - Required: the cycle after release shows `pc`=0x8000_000C.
- Unstalled branch: `br_e`=1, `br_addr`=0x8000_0100 at `pc`=0x8000_0010.
  - Required: next `pc`=0x8000_0100 with `pc_valid`=1.
  - Required: `fetch_cnt` does not count the 0x8000_0010 cycle.
- Redirect during stall: `br_e` with 0x8000_0200 while `stall[0]`=1, then a second `br_e` with 0x8000_0300 while still stalled, then release stall.
  - Required: `pc_valid`=0 while pending.
  - Required: first unstalled edge gives `pc`=0x8000_0300; 0x8000_0200 is never fetched.
- Misaligned target: `br_addr`=0x8000_0402.
  - Required: `fetch_misalign`=1, `pc_valid`=0, `inst_sram_en`=0, `pc` stuck at 0x8000_0402.
  - Required: a later `br_e` to 0x8000_0500 clears it.
- Mid-operation reset: assert `rst` asynchronously with `pend_v`=1 and `fetch_cnt`=7.
  - Required: outputs take reset values immediately.
  - Required: after release, fetch restarts at `RESET_PC` and the pending target is discarded.
